// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, bit-mixing functions and the compression core's state encoding.

package sha256_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StCompute, StFinal} state_e;

    localparam logic [255:0] ShaIv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: maps working variables a..h to their next values.

module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    logic [31:0] t1, t2;

    assign t1 = h_i + big_sigma1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    assign t2 = big_sigma0(a_i) + maj(a_i, b_i, c_i);

    assign a_o = t1 + t2;
    assign b_o = a_i;
    assign c_o = b_i;
    assign d_o = c_i;
    assign e_o = d_i + t1;
    assign f_o = e_i;
    assign g_o = f_i;
    assign h_o = g_i;

endmodule

// File: rtl/sha256_core_param.sv
// SHA-256 block compression core running UNROLL rounds per cycle, with IV chaining and a
// request/ready word-fetch bus for the 16 message words.

module sha256_core_param
    import sha256_pkg::*;
#(
    parameter int unsigned UNROLL = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         chain_i,
    input  logic [255:0] state_in_i,
    input  logic         rdy_i,
    input  logic [31:0]  data_i,
    output logic [3:0]   addr_o,
    output logic         rq_o,
    output logic [255:0] state_out_o,
    output logic         busy_o,
    output logic         done_o
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16))
    begin : g_bad_unroll
        $error("sha256_core_param: UNROLL must be 1, 2, 4, 8 or 16");
    end

    localparam logic [6:0] Step = 7'(UNROLL);

    state_e      state_q;
    logic [31:0] h_q [8];
    logic [31:0] v_q [8];
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [3:0]  idx_q;
    logic [6:0]  t_q;
    logic        rq_q, done_q, busy_q;

    logic [31:0]  wt [UNROLL];
    logic [31:0]  kt [UNROLL];
    logic [255:0] st [UNROLL+1];
    logic [255:0] h_flat;
    logic [255:0] iv;

    assign h_flat = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
    assign iv     = chain_i ? h_flat : state_in_i;
    assign st[0]  = {v_q[0], v_q[1], v_q[2], v_q[3], v_q[4], v_q[5], v_q[6], v_q[7]};

    // The buffer slot for round r is r mod 16; a new W[r] overwrites W[r-16] in place, and
    // later rounds of the same cycle read the freshly written words.
    always_comb begin
        logic [3:0] slot;
        slot = '0;
        w_d  = w_q;
        for (int j = 0; j < int'(UNROLL); j++) begin
            slot = t_q[3:0] + 4'(j);
            if (t_q + 7'(j) >= 7'd16) begin
                w_d[slot] = small_sigma1(w_d[slot - 4'd2]) + w_d[slot - 4'd7]
                          + small_sigma0(w_d[slot - 4'd15]) + w_d[slot];
            end
            wt[j] = w_d[slot];
            kt[j] = K[t_q[5:0] + 6'(j)];
        end
    end

    for (genvar j = 0; j < int'(UNROLL); j++) begin : g_round
        logic [31:0] a_n, b_n, c_n, d_n, e_n, f_n, g_n, h_n;

        sha256_round u_round (
            .a_i (st[j][255:224]),
            .b_i (st[j][223:192]),
            .c_i (st[j][191:160]),
            .d_i (st[j][159:128]),
            .e_i (st[j][127:96]),
            .f_i (st[j][95:64]),
            .g_i (st[j][63:32]),
            .h_i (st[j][31:0]),
            .k_i (kt[j]),
            .w_i (wt[j]),
            .a_o (a_n),
            .b_o (b_n),
            .c_o (c_n),
            .d_o (d_n),
            .e_o (e_n),
            .f_o (f_n),
            .g_o (g_n),
            .h_o (h_n)
        );

        assign st[j+1] = {a_n, b_n, c_n, d_n, e_n, f_n, g_n, h_n};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            t_q     <= '0;
            rq_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        for (int i = 0; i < 8; i++) begin
                            h_q[i] <= iv[255-32*i -: 32];
                            v_q[i] <= iv[255-32*i -: 32];
                        end
                        idx_q   <= '0;
                        rq_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (rq_q && rdy_i) begin
                        w_q[idx_q] <= data_i;
                        idx_q      <= idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            rq_q    <= 1'b0;
                            t_q     <= '0;
                            state_q <= StCompute;
                        end
                    end
                end
                StCompute: begin
                    for (int i = 0; i < 8; i++) begin
                        v_q[i] <= st[UNROLL][255-32*i -: 32];
                    end
                    w_q <= w_d;
                    t_q <= t_q + Step;
                    if (t_q + Step == 7'd64) begin
                        state_q <= StFinal;
                    end
                end
                StFinal: begin
                    for (int i = 0; i < 8; i++) begin
                        h_q[i] <= h_q[i] + v_q[i];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign addr_o      = (state_q == StLoad) ? idx_q : 4'd0;
    assign rq_o        = rq_q;
    assign state_out_o = h_flat;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
